// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin front-end sharing one multicycle combinational FPU between two requesters
module fpu_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_nan,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_nan,
  output logic             busy,
  output logic [CNT_W-1:0] nan_count
);
  localparam int WW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, owner, grant, any_valid, accept, capture, consume;
  logic [WW-1:0] cnt;
  assign any_valid = req0_valid | req1_valid;
  // on a tie the requester that was not served last wins
  assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) & any_valid & ~grant;
  assign req1_ready = (state == IDLE) & any_valid & grant;
  assign accept = req0_ready | req1_ready;
  assign capture = (state == EXEC) & (cnt == WW'(1));
  assign consume = owner ? rsp1_ready : rsp0_ready;
  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? EXEC : IDLE;
    else if (state == EXEC) state_nx = capture ? RESP : EXEC;
    else state_nx = consume ? IDLE : RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpu_a <= '0;
      fpu_b <= '0;
      fpu_op <= '0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      rsp_result <= '0;
      rsp_nan <= 1'b0;
      nan_count <= '0;
    end else begin
      if (accept) begin
        fpu_a <= grant ? req1_a : req0_a;
        fpu_b <= grant ? req1_b : req0_b;
        fpu_op <= grant ? req1_op : req0_op;
        owner <= grant;
        cnt <= WW'(WAIT_CYCLES);
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        rsp_result <= fpu_result;
        rsp_nan <= fpu_nan;
        if (fpu_nan && !(&nan_count)) nan_count <= nan_count + 1'b1;
      end
      if (state == RESP && consume) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed table, corner sequences and randomized model check of fpu_arbiter
module tb_fpu_arbiter;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result, fpu_a, fpu_b, fpu_result;
  logic rsp_nan, fpu_nan, busy;
  logic [1:0] fpu_op, nan_count;
  logic w_req0_valid, w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid;
  logic [31:0] w_rsp_result, w_fpu_a, w_fpu_b, w_fpu_result;
  logic w_rsp_nan, w_fpu_nan, w_busy;
  logic [1:0] w_fpu_op;
  logic [15:0] w_nan_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  function automatic logic is_nan(input logic [31:0] f);
    return f[30:23] == 8'hFF && f[22:0] != 23'd0;
  endfunction
  function automatic real f2r(input logic [31:0] f);
    if (f[30:0] == 31'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction
  // behavioural stand-in for the external FPU datapath
  function automatic logic [32:0] fpu_m(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real x, y, r;
    if (is_nan(a) || is_nan(b)) return {1'b1, 32'h7FC00000};
    x = f2r(a);
    y = f2r(b);
    r = op == 2'd0 ? x + y : op == 2'd1 ? x - y : op == 2'd2 ? x * y : x / y;
    return {1'b0, r2f(r)};
  endfunction
  always_comb {fpu_nan, fpu_result} = fpu_m(fpu_a, fpu_b, fpu_op);
  always_comb {w_fpu_nan, w_fpu_result} = fpu_m(w_fpu_a, w_fpu_b, w_fpu_op);
  fpu_arbiter #(.WAIT_CYCLES(W), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_nan(rsp_nan), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_nan(fpu_nan), .busy(busy), .nan_count(nan_count)
  );
  fpu_arbiter #(.WAIT_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(32'h40400000), .req0_b(32'h40000000), .req0_op(2'd2),
    .req1_valid(1'b0), .req1_ready(w_req1_ready), .req1_a(32'h0), .req1_b(32'h0), .req1_op(2'd0),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(1'b1), .rsp1_valid(w_rsp1_valid), .rsp1_ready(1'b1),
    .rsp_result(w_rsp_result), .rsp_nan(w_rsp_nan), .fpu_a(w_fpu_a), .fpu_b(w_fpu_b), .fpu_op(w_fpu_op),
    .fpu_result(w_fpu_result), .fpu_nan(w_fpu_nan), .busy(w_busy), .nan_count(w_nan_count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // requester n already presents its op; wait grant, check latency/result, consume
  task automatic serve(input int n, input logic [31:0] er, input logic en);
    int k;
    #1;
    k = 0;
    while (!(n ? req1_ready : req0_ready) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("grant", n ? req1_ready : req0_ready, 1);
    chk("nongrant", n ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
    k = 0;
    while (!(n ? rsp1_valid : rsp0_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, W);
    chk("result", rsp_result, er);
    chk("nan", rsp_nan, en);
    chk("other_rsp", n ? rsp0_valid : rsp1_valid, 0);
    chk("busy_resp", busy, 1);
    if (n) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("rsp_drop", n ? rsp1_valid : rsp0_valid, 0);
    chk("busy_idle", busy, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask
  typedef struct {
    int n;
    logic [31:0] a, b;
    logic [1:0] op;
    logic [31:0] res;
    logic nan;
    logic [1:0] cnt;
  } vec_t;
  vec_t tbl[5];
  logic [31:0] vals[8];
  int acc_c[$], rsp_c[$];
  int cyc, acc_e;
  bit pend, own, last, g, ev, e_r0, e_r1, a0, a1;
  logic [1:0] ncnt, fop;
  logic [31:0] fa, fb, eres;
  logic enan;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{0, 32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 1'b0, 2'd0};
    tbl[1] = '{1, 32'h40000000, 32'h40400000, 2'd2, 32'h40C00000, 1'b0, 2'd0};
    tbl[2] = '{0, 32'h40A00000, 32'h3F800000, 2'd1, 32'h40800000, 1'b0, 2'd0};
    tbl[3] = '{1, 32'h40C00000, 32'h40000000, 2'd3, 32'h40400000, 1'b0, 2'd0};
    tbl[4] = '{1, 32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 1'b1, 2'd1};
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40A00000,
             32'h3F000000, 32'hBF800000, 32'h7FC00000, 32'h40800000};
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready, w_req0_valid} = '0;
    {req0_a, req0_b, req1_a, req1_b, req0_op, req1_op} = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_nan_count", nan_count, 0);
    chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp_nan}, 0);
    @(negedge clk) rst_n = 1'b1;
    // one-cycle settle: accept every 3 cycles with consumer always ready
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      w_req0_valid = 1'b1;
      #1;
      if (w_req0_ready) acc_c.push_back(c);
      if (w_rsp0_valid) begin
        rsp_c.push_back(c);
        chk("w1_result", w_rsp_result, 32'h40C00000);
      end
    end
    chk("w1_accepts", acc_c.size(), 5);
    for (int i = 0; i + 1 < acc_c.size(); i++) chk("w1_spacing", acc_c[i+1] - acc_c[i], 3);
    for (int i = 0; i < rsp_c.size() && i < acc_c.size(); i++) chk("w1_latency", rsp_c[i] - acc_c[i], 2);
    // tie after reset goes to req0, then alternates
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_op = 2'd2; req0_valid = 1'b1;
    req1_a = 32'h40A00000; req1_b = 32'h3F800000; req1_op = 2'd1; req1_valid = 1'b1;
    serve(0, 32'h40C00000, 1'b0);
    req0_valid = 1'b1;
    serve(1, 32'h40800000, 1'b0);
    req1_valid = 1'b1;
    serve(0, 32'h40C00000, 1'b0);
    serve(1, 32'h40800000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].n != 0) begin
        req1_a = tbl[i].a; req1_b = tbl[i].b; req1_op = tbl[i].op; req1_valid = 1'b1;
      end else begin
        req0_a = tbl[i].a; req0_b = tbl[i].b; req0_op = tbl[i].op; req0_valid = 1'b1;
      end
      serve(tbl[i].n, tbl[i].res, tbl[i].nan);
      chk("tbl_nan_count", nan_count, tbl[i].cnt);
    end
    // back-pressure on req0's response with req1 waiting
    req0_a = 32'h3F800000; req0_b = 32'h3F800000; req0_op = 2'd0; req0_valid = 1'b1;
    req1_a = 32'h40A00000; req1_b = 32'h3F800000; req1_op = 2'd1; req1_valid = 1'b1;
    #1;
    chk("bp_grant0", req0_ready, 1);
    chk("bp_grant1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp0_valid, 1);
      chk("bp_result", rsp_result, 32'h40000000);
      chk("bp_busy", busy, 1);
      chk("bp_req1_ready", req1_ready, 0);
      chk("bp_rsp1", rsp1_valid, 0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    chk("bp_release", rsp0_valid, 0);
    chk("bp_idle", busy, 0);
    chk("bp_next_ready", req1_ready, 1);
    serve(1, 32'h40800000, 1'b0);
    // NaN counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      req1_a = 32'h7FC00000; req1_b = 32'h3F800000; req1_op = 2'd0; req1_valid = 1'b1;
      serve(1, 32'h7FC00000, 1'b1);
      chk("sat_count", nan_count, i == 0 ? 2 : 3);
    end
    // reset one cycle after accept drops the op
    req0_a = 32'h40000000; req0_b = 32'h40000000; req0_op = 2'd2; req0_valid = 1'b1;
    #1;
    chk("mr_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_fpu_a", fpu_a, 0);
    chk("mr_fpu_op", fpu_op, 0);
    chk("mr_result", rsp_result, 0);
    chk("mr_busy", busy, 0);
    chk("mr_count", nan_count, 0);
    chk("mr_rsp", {rsp0_valid, rsp1_valid}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("mr_no_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    end
    req0_valid = 1'b1;
    serve(0, 32'h40800000, 1'b0);
    // randomized traffic against a transaction-level model
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = '0;
    do_reset();
    cyc = 0; pend = 0; own = 0; last = 1; ncnt = 0; fa = 0; fb = 0; fop = 0;
    a0 = 0; a1 = 0; acc_e = 0; eres = 0; enan = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1'b1; req0_a = vals[$urandom_range(7)]; req0_b = vals[$urandom_range(7)]; req0_op = 2'($urandom_range(3));
      end
      if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1'b1; req1_a = vals[$urandom_range(7)]; req1_b = vals[$urandom_range(7)]; req1_op = 2'($urandom_range(3));
      end
      rsp0_ready = 1'($urandom_range(1));
      rsp1_ready = 1'($urandom_range(1));
      #1;
      g = (req0_valid && req1_valid) ? !last : req1_valid;
      e_r0 = !pend && (req0_valid || req1_valid) && !g;
      e_r1 = !pend && (req0_valid || req1_valid) && g;
      ev = pend && cyc >= acc_e + W;
      chk("rnd_ready0", req0_ready, e_r0);
      chk("rnd_ready1", req1_ready, e_r1);
      chk("rnd_rsp0", rsp0_valid, ev && !own);
      chk("rnd_rsp1", rsp1_valid, ev && own);
      chk("rnd_busy", busy, pend);
      chk("rnd_count", nan_count, ncnt);
      chk("rnd_fpu_a", fpu_a, fa);
      chk("rnd_fpu_b", fpu_b, fb);
      chk("rnd_fpu_op", fpu_op, fop);
      if (ev) begin
        chk("rnd_result", rsp_result, eres);
        chk("rnd_nan", rsp_nan, enan);
      end
      a0 = e_r0;
      a1 = e_r1;
      if (e_r0 || e_r1) begin
        pend = 1; own = g; acc_e = cyc + 1;
        fa = g ? req1_a : req0_a; fb = g ? req1_b : req0_b; fop = g ? req1_op : req0_op;
        {enan, eres} = fpu_m(fa, fb, fop);
      end else if (ev && (own ? rsp1_ready : rsp0_ready)) begin
        pend = 0;
        last = own;
      end
      if (pend && cyc + 1 == acc_e + W) ncnt = (ncnt == 2'd3) ? 2'd3 : ncnt + {1'b0, enan};
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
Sequential front-end that shares one combinational FPU datapath (add/sub/mul/div, 2-bit opcode, 32-bit IEEE-754 operands, NaN flag) between two requesters.
- Round-robin arbitration with a valid/ready request handshake.
- Operands and opcode are registered and held stable to the FPU for a programmable settle time, so the long combinational path runs as a multicycle path.
- The result and NaN flag are captured and returned to the owning requester through a valid/ready response handshake.
- Also keeps a saturating count of NaN results.

Parameters:
WAIT_CYCLES, 2, cycles the FPU inputs are held before the result is sampled; legal range ≥1.
CNT_W, 16, width of the NaN result counter.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  requester 0 operand A
req0_b  in  32  requester 0 operand B
req0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp1_valid  out  1  result available for requester 1
rsp1_ready  in  1  requester 1 consumes result
rsp_result  out  32  captured FPU result, shared by both requesters
rsp_nan  out  1  captured FPU NaN flag
fpu_a  out  32  registered operand A to FPU
fpu_b  out  32  registered operand B to FPU
fpu_op  out  2  registered opcode to FPU
fpu_result  in  32  FPU result
fpu_nan  in  1  FPU NaN flag
busy  out  1  high in any state other than IDLE
nan_count  out  CNT_W  saturating count of captured results with NaN flag set

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: fpu_a/b/op, rsp_result, rsp_nan, rsp*_valid, nan_count, busy.
  - last_grant=1, so requester 0 wins the first tie.
  - Wait counter 0.
- Reset asserted mid-operation: the in-flight operation is dropped and no response is issued.

- States: IDLE, EXEC, RESP.

- IDLE:
  - Grant is computed combinationally from the valids:
    - only one valid → that requester;
    - both valid → the requester ≠ last_grant;
    - none valid → no grant.
  - reqN_ready = (state==IDLE) && grant==N. Never asserted outside IDLE, never asserted without reqN_valid.
  - On the edge with valid&&ready:
    - fpu_a/b/op ← granted requester's operands;
    - owner ← N;
    - counter ← WAIT_CYCLES;
    - → EXEC.

- EXEC:
  - fpu_* held constant.
  - Counter decrements each cycle.
  - On the edge where counter==1:
    - rsp_result ← fpu_result, rsp_nan ← fpu_nan;
    - nan_count += fpu_nan, saturating at all-ones;
    - → RESP.
  - Latency: the accept edge is T0; capture is at edge T0+WAIT_CYCLES; rsp_valid is high from that edge.

- RESP:
  - rsp<owner>_valid=1; the other rsp*_valid stays 0.
  - rsp_result and rsp_nan are held stable until consumed.
  - On the edge with rsp<owner>_ready=1:
    - rsp valid drops;
    - last_grant ← owner;
    - → IDLE.
  - Earliest next accept is the cycle after return to IDLE, giving a throughput of one op per WAIT_CYCLES+2 cycles.
  - rsp*_ready is ignored outside RESP and for the non-owner.

- fpu_* retain their last values in IDLE; there is no clearing between ops.
- Requesters hold valid and operands stable until ready. A valid dropped before grant is simply not serviced.
- Divide opcode is passed through unchanged; rsp_nan reflects fpu_nan whatever the opcode.

Test Plan:
1. WAIT_CYCLES=2, real FPU attached; req0 add A=3F800000, B=40000000 → req0_ready at T0; rsp0_valid rises at T0+2; rsp_result=40400000, rsp_nan=0; rsp1_valid stays 0.
2. Tie after reset: req0 (mul 40000000×40400000) and req1 (sub 40A00000−3F800000) both valid → req0 served first with result 40C00000; req1 then served with 40800000; the next tie grants req0 again (alternation).
3. Back-pressure: hold rsp0_ready=0 for 5 cycles in RESP → rsp0_valid and rsp_result stay stable, busy=1, req1_ready=0 throughout; release → IDLE next edge.
4. NaN: req1 add 7FC00000+3F800000 → rsp_nan=1, nan_count 0→1. With CNT_W=2, four more NaN ops → count saturates at 3.
5. Reset mid-EXEC: assert rst_n=0 one cycle after accept → all outputs 0 asynchronously; no rsp valid after release; the next op completes normally with correct latency.
6. WAIT_CYCLES=1 boundary: accept at T0 → rsp valid at T0+1; back-to-back ops with rsp_ready tied high → accept every 3 cycles.
